spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI slave front end of digit_recognizer_final; sits directly upstream of the command/image-load logic and downstream of the external SPI master.
- Synchronises the asynchronous SCK/SS/MOSI into the clk domain and deserialises LSB-first bytes into a parallel rx byte plus a one-cycle valid strobe.
- Serialises a preloaded tx byte (classification result / cost) onto MISO, LSB first.
- One byte per SS-low frame is the normal case; longer frames are handled.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser (legal ≥2).
- BYTE_W, 8: bits per transferred word.
- MISO_IDLE, 1'b1: MISO level while SS is high.

Ports:
- clk  input  1  system clock (≥8x SCK frequency)
- n_rst  input  1  asynchronous active-low reset
- SCK  input  1  SPI clock from master, idle low, asynchronous to clk
- SS  input  1  slave select, active low, asynchronous
- MOSI  input  1  master data; master changes it on SCK falling, slave samples it on SCK rising
- MISO  output  1  slave data; changes after SCK falling, master samples it on SCK rising
- rx_data  output  BYTE_W  last complete received byte
- rx_valid  output  1  one-clk pulse when rx_data updates
- tx_data  input  BYTE_W  byte to send in the next frame
- tx_load  input  1  capture tx_data into the tx holding register
- tx_pending  output  1  holding register loaded and not yet sent

Behaviour:
- Reset (async, n_rst low): rx_data=0, rx_valid=0, MISO=MISO_IDLE, tx_pending=0, holding=0, shift regs=0, bit count=0, state=IDLE, synchronisers reset to idle (SCK=0, SS=1).
- Synchronisation: SCK, SS and MOSI each pass through SYNC_STAGES FFs. Edge detects on synced SCK and SS use one extra FF. MOSI is sampled from its synced copy on a detected SCK rise, so MOSI and SCK have equal delay.
- FSM states:
  - IDLE: waiting for SS fall.
  - ACTIVE: SS low, shifting.
  - On an SS falling edge: go to ACTIVE, clear bit_cnt, copy holding into tx_shift, clear tx_pending. MISO=holding[0] from the next clk.
  - In ACTIVE, on an SCK rise: rx_shift <= {MOSI_s, rx_shift[BYTE_W-1:1]} (LSB first), bit_cnt++.
  - When bit_cnt reaches BYTE_W-1 on that rise: next cycle rx_data <= completed byte, rx_valid=1 for exactly one clk, bit_cnt wraps to 0. Latency is SYNC_STAGES+2 clk from the physical 8th SCK rise.
  - In ACTIVE, on an SCK fall: tx_shift shifts right with MISO_IDLE fill; MISO=tx_shift[1] (next bit). After BYTE_W bits, MISO outputs MISO_IDLE.
  - On an SS rising edge: return to IDLE, MISO=MISO_IDLE. A partial byte (bit_cnt≠0) is discarded with no rx_valid.
- Frames longer than BYTE_W bits produce a byte every BYTE_W rises, each with its own rx_valid.
- tx_load: holding <= tx_data and tx_pending=1.
  - If tx_load coincides with a detected SS fall, the new tx_data is copied directly to tx_shift and tx_pending stays 0.
  - A second tx_load before a frame overwrites the holding register.
  - If no tx_load occurred since the last frame, the stale holding value is resent.
- SCK edges while SS is high are ignored. An SS fall and SCK rise detected in the same clk: the SS fall is processed first, then the rise is accepted in the same cycle.

Optional Feature:
- Macro SPI_SLAVE_FRAME_ERR_EN.
- When defined: adds output frame_err (1 bit, reset 0). It pulses for one clk when SS rises with bit_cnt≠0, and it also pulses on any SCK rise while in IDLE.
- When undefined: the port and its logic are absent, and partial bytes are silently dropped.

Decomposition:
- Package spi_pkg: BYTE_W constant, spi_state_t enum {IDLE, ACTIVE}, and a bit-count type sized $clog2(BYTE_W).
- Sub-module spi_sync_edge: a SYNC_STAGES synchroniser with rise/fall pulse outputs. It is instantiated for SCK and SS; MOSI uses the synchroniser only.

Test Plan:
- Reset mid-frame (n_rst low after 3 bits, then release): all outputs return to reset values immediately, and the next full frame with 0xA5 gives rx_data=0xA5 with exactly one rx_valid.
- Send 0x00, then 0xFF, then 0x5A, each in its own frame, SCK period 83 ns, clk 5 ns: rx_valid pulses three times, and rx_data equals 0x00, 0xFF, 0x5A respectively.
- tx_load 0x07, then a read frame with MOSI=1: the master collects LSB-first 0x07, tx_pending goes 1→0 at SS fall, and MISO is 1 when SS is high.
- Abort frame after 5 bits (SS high): no rx_valid (frame_err pulses when the macro is defined), and the next byte 0x3C is received cleanly.
- 16-bit frame 0x1234 with SS held low: two rx_valid pulses, 0x34 then 0x12; MISO outputs the tx byte and then 1s.
- tx_load 0x09 in the same clk as the detected SS fall: the master reads 0x09, and tx_pending stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI slave front end.
//   BYTE_W      : default bits per transferred word
//   CNT_W       : width of a bit counter for BYTE_W bits
//   bit_cnt_t   : bit-count type sized $clog2(BYTE_W)
//   spi_state_t : frame FSM states (IDLE waits for SS fall, ACTIVE shifts)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W);

    typedef logic [CNT_W-1:0] bit_cnt_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by one extra
// flop used to produce single-cycle rise/fall pulses on the synced level.
// Ports:
//   clk   : system clock
//   n_rst : asynchronous active-low reset (chain resets to RESET_VAL)
//   din   : asynchronous input
//   dout  : synchronised level (STAGES clk of delay)
//   rise  : one-clk pulse when dout goes 0 -> 1
//   fall  : one-clk pulse when dout goes 1 -> 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: non-blocking assignments so every stage takes its predecessor's
    // old value; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise =  dout & ~prev_q;
    assign fall = ~dout &  prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// SPI slave front end (mode 0, LSB first). Synchronises SCK/SS/MOSI into the
// clk domain, deserialises bytes into rx_data with a one-clk rx_valid, and
// shifts a preloaded tx byte out on MISO.
// Ports:
//   clk, n_rst         : system clock, async active-low reset
//   SCK, SS, MOSI      : asynchronous SPI inputs from the master
//   MISO               : serial data to master (MISO_IDLE while SS high)
//   rx_data, rx_valid  : last complete byte and its one-clk strobe
//   tx_data, tx_load   : byte for the next frame and its capture strobe
//   tx_pending         : holding register loaded and not yet sent
//   frame_err          : (only with SPI_SLAVE_FRAME_ERR_EN) one-clk pulse on an
//                        aborted partial byte or an SCK rise outside a frame
// Build option: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_slave_if #(
    parameter int   SYNC_STAGES = 2,
    parameter int   BYTE_W      = spi_pkg::BYTE_W,
    parameter logic MISO_IDLE   = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_pending
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    import spi_pkg::*;

    localparam int CW = $clog2(BYTE_W);

    // ---------------- input synchronisation ----------------
    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .n_rst(n_rst), .din(SCK),
        .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .n_rst(n_rst), .din(SS),
        .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    // MOSI gets the same depth as SCK so the bit seen on a detected rise is
    // the one the master presented at that rise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // ---------------- FSM ----------------
    spi_state_t state_q, state_d;
    logic start_frame, end_frame, sample, shift_out;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A rise detected together with the SS fall is accepted in that cycle.
    always_comb begin
        start_frame = 1'b0;
        end_frame   = 1'b0;
        sample      = 1'b0;
        shift_out   = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_frame = ss_fall;
                sample      = ss_fall & sck_rise;
            end
            ACTIVE: begin
                end_frame = ss_rise;
                sample    = sck_rise & ~ss_rise;
                shift_out = sck_fall & ~ss_rise;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    logic [BYTE_W-1:0] rx_shift_q, tx_shift_q, holding_q, frame_tx;
    logic [CW-1:0]     bit_cnt_q, cnt_base;
    logic              byte_last, byte_done_q;

    // A tx_load coinciding with the frame start bypasses the holding register.
    assign frame_tx  = tx_load ? tx_data : holding_q;
    assign cnt_base  = start_frame ? '0 : bit_cnt_q;
    assign byte_last = (cnt_base == CW'(BYTE_W - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            holding_q   <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_pending  <= 1'b0;
            MISO        <= MISO_IDLE;
        end else begin
            byte_done_q <= sample & byte_last;
            rx_valid    <= byte_done_q;
            if (byte_done_q) rx_data <= rx_shift_q;

            if (start_frame) begin
                tx_shift_q <= frame_tx;
                MISO       <= frame_tx[0];
                bit_cnt_q  <= '0;
            end else if (shift_out) begin
                tx_shift_q <= {MISO_IDLE, tx_shift_q[BYTE_W-1:1]};
                MISO       <= tx_shift_q[1];
            end else if (end_frame) begin
                MISO      <= MISO_IDLE;
                bit_cnt_q <= '0;
            end

            if (sample) begin
                rx_shift_q <= {mosi_s, rx_shift_q[BYTE_W-1:1]};
                bit_cnt_q  <= byte_last ? '0 : cnt_base + CW'(1);
            end

            if (tx_load) begin
                holding_q  <= tx_data;
                tx_pending <= ~start_frame;
            end else if (start_frame) begin
                tx_pending <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) frame_err <= 1'b0;
        else        frame_err <= (end_frame & (bit_cnt_q != '0))
                               | ((state_q == IDLE) & sck_rise & ~ss_fall);
    end
`endif

    // Synced SCK/SS levels are only consumed through their edge pulses.
    logic unused_levels;
    assign unused_levels = sck_s ^ ss_s;

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
// Self-checking bench for spi_slave_if: a behavioural SPI master drives frames,
// expected rx bytes go into a scoreboard queue and are popped as rx_valid
// pulses arrive; MISO bits collected by the master are compared directly.
// Define SPI_SLAVE_FRAME_ERR_EN to also exercise frame_err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       SCK, SS, MOSI, MISO;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, tx_load, tx_pending;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
`endif

    int tests  = 0;
    int errors = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] sb[$];

    always #2.5 clk = ~clk;

    spi_slave_if dut (
        .clk(clk), .n_rst(n_rst),
        .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_pending(tx_pending)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every rx_valid must match the oldest expected byte.
    always @(negedge clk) begin
        if (n_rst && rx_valid) begin
            rv_cnt++;
            if (sb.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hxxxx_xxxx);
            else                check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (n_rst && frame_err) fe_cnt++;
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic load_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic sck_bit(input logic b, output logic miso_smp);
        MOSI = b;
        #41 SCK = 1'b1;
        miso_smp = MISO;
        #42 SCK = 1'b0;
    endtask

    // One SS-low frame of nbits (LSB first). With load_at_fall set, tx_load is
    // asserted in the clk where the synchronised SS fall is detected.
    task automatic frame(input logic [15:0] mo, input int nbits, input bit load_at_fall,
                         input logic [7:0] ld, output logic [15:0] mi);
        logic s;
        mi = '0;
        @(negedge clk);
        SS = 1'b0;
        if (load_at_fall) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            tx_data = ld;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
        end
        #40;
        for (int i = 0; i < nbits; i++) begin
            sck_bit(mo[i], s);
            mi[i] = s;
        end
        #40 SS = 1'b1;
        #100;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [15:0] mi);
        sb.push_back(b);
        frame({8'h00, b}, 8, 1'b0, 8'h00, mi);
    endtask

    initial begin
        logic [15:0] mi;
        logic        s;
        int          rv0;

        n_rst = 1'b0; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
        tx_data = '0; tx_load = 1'b0;

        // Reset state
        #20;
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_miso", 32'(MISO), 32'h1);
        check("rst_tx_pending", 32'(tx_pending), 32'h0);
        n_rst = 1'b1;
        #50;

        // Three single-byte frames
        rv0 = rv_cnt;
        send_byte(8'h00, mi);
        send_byte(8'hFF, mi);
        send_byte(8'h5A, mi);
        check("three_frames_valid_cnt", 32'(rv_cnt - rv0), 32'd3);

        // Reset in the middle of a frame, with a pending tx byte
        SS = 1'b0;
        #40;
        sck_bit(1'b1, s);
        load_tx(8'h66);
        sck_bit(1'b0, s);
        sck_bit(1'b1, s);
        n_rst = 1'b0;
        #1;
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        check("midrst_rx_valid", 32'(rx_valid), 32'h0);
        check("midrst_miso", 32'(MISO), 32'h1);
        check("midrst_tx_pending", 32'(tx_pending), 32'h0);
        SS = 1'b1;
        #50 n_rst = 1'b1;
        #50;
        rv0 = rv_cnt;
        send_byte(8'hA5, mi);
        check("after_rst_valid_cnt", 32'(rv_cnt - rv0), 32'd1);

        // Read frame: preload 0x07, master shifts 1s in
        load_tx(8'h07);
        #1 check("tx_pending_set", 32'(tx_pending), 32'h1);
        send_byte(8'hFF, mi);
        check("read_07_miso", 32'(mi), 32'h0007);
        check("tx_pending_clr", 32'(tx_pending), 32'h0);
        check("miso_idle_ss_high", 32'(MISO), 32'h1);

        // SCK pulse outside a frame, then an aborted 5-bit frame
        rv0 = rv_cnt;
        #41 SCK = 1'b1;
        #42 SCK = 1'b0;
        #100;
        frame(16'h001F, 5, 1'b0, 8'h00, mi);
        check("abort_no_valid", 32'(rv_cnt - rv0), 32'd0);
        send_byte(8'h3C, mi);
        check("stale_resend_07", 32'(mi), 32'h0007);
        check("clean_3c_valid_cnt", 32'(rv_cnt - rv0), 32'd1);

        // 16-bit frame: two bytes in, tx byte then idle 1s out
        load_tx(8'hC3);
        rv0 = rv_cnt;
        sb.push_back(8'h34);
        sb.push_back(8'h12);
        frame(16'h1234, 16, 1'b0, 8'h00, mi);
        check("long_frame_valid_cnt", 32'(rv_cnt - rv0), 32'd2);
        check("long_frame_miso", 32'(mi), 32'hFFC3);

        // tx_load in the same clk as the detected SS fall
        sb.push_back(8'h81);
        frame(16'h0081, 8, 1'b1, 8'h09, mi);
        check("load_at_fall_miso", 32'(mi), 32'h0009);
        check("load_at_fall_pending", 32'(tx_pending), 32'h0);

        #200;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err_cnt", 32'(fe_cnt), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
